// File: rtl/jump_target_encoder_pkg.sv
// Shared J-format encoding constants and the result entry carried through the buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jump_target_encoder_pkg;

  localparam int FIELD_W  = 26;  // J-format instr_index width
  localparam int REGION_W = 4;   // upper PC bits a J-type jump cannot change
  localparam int ALIGN_W  = 2;   // byte-offset bits that must be zero for a word target

  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic               misaligned;
    logic               region_err;
  } result_t;

endpackage

// File: rtl/jump_target_encoder_result_fifo.sv
// Result buffer: DEPTH-entry circular FIFO of encoded results with occupancy count.
// Latency: a pushed entry is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: full/empty derive from the registered count only; caller gates push/pop.
module jte_result_fifo
  import jump_target_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  result_t                      wr_data,
  input  logic                         pop,
  output result_t                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t            mem [0:DEPTH-1];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Guard against overflow/underflow regardless of what the caller asks for.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Storage is deliberately left unreset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap at DEPTH (not a power of two in general); count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Status flags and a head view that reads zero when nothing is buffered.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    rd_data = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/jump_target_encoder.sv
// Encodes a jump byte address into the J-format instr_index and flags misalignment / region errors.
// Latency: one cycle from accept to out_valid through an OUT_DEPTH-entry result buffer.
// Backpressure: in_ready depends only on buffer occupancy, never combinationally on out_ready.
module jump_target_encoder
  import jump_target_encoder_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int ERR_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_target,
  input  logic [31:0]        in_pc_plus4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic               out_misaligned,
  output logic               out_region_err,
  output logic               out_ok,
  output logic [ERR_W-1:0]   err_count
);

  result_t                          enc;
  result_t                          head;
  logic [$clog2(OUT_DEPTH+1)-1:0]   count;
  logic                             full;
  logic                             empty;
  logic                             accept;
  logic                             pop;
  logic                             pc_low_unused;

  // Only the region nibble of PC+4 participates in the check.
  assign pc_low_unused = ^in_pc_plus4[31-REGION_W:0];

  // Encode the request: drop byte offset, keep 26 index bits, check alignment and region.
  always_comb begin
    enc.field      = in_target[ALIGN_W +: FIELD_W];
    enc.misaligned = |in_target[ALIGN_W-1:0];
    enc.region_err = (in_target[31 -: REGION_W] != in_pc_plus4[31 -: REGION_W]);
  end

  // Handshakes: readiness comes from registered occupancy, so full blocks even with out_ready high.
  always_comb begin
    in_ready  = !full;
    out_valid = !empty;
    accept    = in_valid && !full;
    pop       = !empty && out_ready;
  end

  jte_result_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .wr_data (enc),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Present the head entry; the FIFO already zeroes it while empty, so out_ok just needs the valid gate.
  always_comb begin
    out_field      = head.field;
    out_misaligned = head.misaligned;
    out_region_err = head.region_err;
    out_ok         = out_valid && !head.misaligned && !head.region_err;
  end

  // Count accepted requests carrying any error, holding at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (accept && (enc.misaligned || enc.region_err) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_target_encoder.sv
// Self-checking bench for jump_target_encoder using a queue-based reference model.
// Latency: model entries become visible one cycle after the accepting edge.
// Backpressure: model accepts only while fewer than DEPTH entries are held.
module tb_jump_target_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_target = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_field;
  logic        out_misaligned;
  logic        out_region_err;
  logic        out_ok;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int unsigned field;
    bit          mis;
    bit          rg;
  } ent_t;

  ent_t mq[$];
  int   merr = 0;

  jump_target_encoder #(.OUT_DEPTH(DEPTH), .ERR_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_target      (in_target),
    .in_pc_plus4    (in_pc_plus4),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_field      (out_field),
    .out_misaligned (out_misaligned),
    .out_region_err (out_region_err),
    .out_ok         (out_ok),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Expected {in_ready, out_valid, field, misaligned, region_err, ok, err_count} from the model.
  function automatic logic [38:0] expv();
    logic [25:0] f = '0;
    logic        m = 1'b0;
    logic        r = 1'b0;
    logic        v = 1'b0;
    if (mq.size() != 0) begin
      v = 1'b1;
      f = 26'(mq[0].field);
      m = mq[0].mis;
      r = mq[0].rg;
    end
    return {(mq.size() < DEPTH), v, f, m, r, (v && !m && !r), 8'(merr)};
  endfunction

  function automatic logic [38:0] dutv();
    return {in_ready, out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count};
  endfunction

  // Advance one clock; the model applies pop-then-push using pre-edge occupancy.
  task automatic tick();
    ent_t e;
    bit   acc;
    bit   pop;
    @(posedge clk);
    acc = in_valid && reset_n && (mq.size() < DEPTH);
    pop = reset_n && (mq.size() != 0) && out_ready;
    e.field = (in_target / 4) % (1 << 26);
    e.mis   = (in_target % 4) != 0;
    e.rg    = (in_target / (1 << 28)) != (in_pc_plus4 / (1 << 28));
    if (pop) mq.delete(0);
    if (acc) begin
      mq.push_back(e);
      if ((e.mis || e.rg) && merr < 255) merr++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mq.delete();
    merr = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dutv() !== {1'b1, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", dutv(), {1'b1, 1'b0, 26'h0, 3'b000, 8'h00});
    end
  endtask

  task automatic test_directed();
    do_reset();
    in_pc_plus4 = 32'h0040_0004;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_target = 32'h0040_0020;
    tick();
    vectors++;
    if ({out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count} !==
        {1'b1, 26'h0100008, 1'b0, 1'b0, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL aligned_target: got v=%b f=%h m=%b r=%b ok=%b e=%0d expected v=1 f=0100008 ok=1 e=0",
               out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count);
    end
    in_target = 32'h0040_0022;
    tick();
    vectors++;
    if ({out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count} !==
        {1'b1, 26'h0100008, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL misaligned_target: got v=%b f=%h m=%b r=%b ok=%b e=%0d expected v=1 f=0100008 m=1 ok=0 e=1",
               out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count);
    end
    in_target = 32'h1000_0000;
    tick();
    vectors++;
    if ({out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count} !==
        {1'b1, 26'h0000000, 1'b0, 1'b1, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL region_target: got v=%b f=%h m=%b r=%b ok=%b e=%0d expected v=1 f=0 r=1 ok=0 e=2",
               out_valid, out_field, out_misaligned, out_region_err, out_ok, err_count);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if ({out_valid, out_field, out_misaligned, out_region_err, out_ok} !== 30'h0) begin
      miscompares++;
      $display("FAIL idle_zero_outputs: got v=%b f=%h m=%b r=%b ok=%b expected all zero",
               out_valid, out_field, out_misaligned, out_region_err, out_ok);
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] drain [0:1];
    drain[0] = 26'h0100040;
    drain[1] = 26'h0100080;
    do_reset();
    in_pc_plus4 = 32'h0040_0004;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_target = 32'h0040_0100 + 32'(i) * 32'h100;
      vectors++;
      if (in_ready !== (i < 2)) begin
        miscompares++;
        $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 2));
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({in_ready, out_valid, out_field} !== {1'b0, 1'b1, drain[0]}) begin
        miscompares++;
        $display("FAIL bp_head_hold[%0d]: got rdy=%b v=%b f=%h expected rdy=0 v=1 f=%h",
                 i, in_ready, out_valid, out_field, drain[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({out_valid, out_field} !== {1'b1, drain[i]}) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: got v=%b f=%h expected v=1 f=%h", i, out_valid, out_field, drain[i]);
      end
      tick();
    end
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_drained: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      in_pc_plus4 = $urandom();
      in_target   = $urandom();
      if ($urandom_range(0, 1) == 0)
        in_target = (in_target % (1 << 28)) + (in_pc_plus4 / (1 << 28)) * (1 << 28);
      if ($urandom_range(0, 3) != 0)
        in_target = in_target - (in_target % 4);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", n, dutv(), expv());
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_pc_plus4 = 32'h0040_0004;
    in_target = 32'h0040_0001;
    for (int n = 0; n < 255; n++) begin
      tick();
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL sat_ramp[%0d]: got %h expected %h", n, dutv(), expv());
      end
    end
    vectors++;
    if (err_count !== 8'hFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h expected ff", err_count);
    end
    tick();
    tick();
    vectors++;
    if (err_count !== 8'hFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %h expected ff", err_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_pc_plus4 = 32'h0040_0004;
    in_valid = 1'b1;
    in_target = 32'h0040_0002;
    tick();
    in_target = 32'h2000_0000;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({in_ready, out_valid, err_count} !== {1'b0, 1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL mid_prefill: got rdy=%b v=%b e=%0d expected rdy=0 v=1 e=2", in_ready, out_valid, err_count);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (dutv() !== {1'b1, 1'b0, 26'h0, 3'b000, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %h expected %h", dutv(), {1'b1, 1'b0, 26'h0, 3'b000, 8'h00});
    end
    mq.delete();
    merr = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      vectors++;
      if ({out_valid, out_field, out_ok, err_count} !== 36'h0) begin
        miscompares++;
        $display("FAIL mid_no_stale[%0d]: got v=%b f=%h ok=%b e=%0d expected all zero",
                 n, out_valid, out_field, out_ok, err_count);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
